// File: rtl/bsg_serial_in_parallel_out_gather.sv
// bsg_serial_in_parallel_out_gather: packs els_p narrow words into one wide beat on valid/yumi
module bsg_serial_in_parallel_out_gather #(
    parameter int width_p = 32,
    parameter int els_p   = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       valid_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       ready_and_o,
    output logic                       valid_o,
    output logic [els_p*width_p-1:0]   data_o,
    input  logic                       yumi_i
);
    localparam int cw = $clog2(els_p + 1);
    logic [cw-1:0] count_r;
    logic [els_p-1:0][width_p-1:0] data_r;
    assign ready_and_o = count_r != cw'(els_p);
    assign valid_o     = count_r == cw'(els_p);
    assign data_o      = data_r;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r <= '0;
            data_r  <= '0;
        end else if (valid_i && ready_and_o) begin
            for (int k = 0; k < els_p; k++)
                if (count_r == cw'(k)) data_r[k] <= data_i;
            count_r <= count_r + cw'(1);
        end else if (yumi_i && valid_o) begin
            count_r <= '0;
        end
    end
    always_ff @(posedge clk_i)
        assert (reset_i || !yumi_i || valid_o)
            else $error("bsg_serial_in_parallel_out_gather: yumi_i asserted while valid_o=0");
endmodule

// File: tb/tb_bsg_serial_in_parallel_out_gather.sv
// tb_bsg_serial_in_parallel_out_gather: directed checks of the gather block (els_p=4 and els_p=1)
module tb_bsg_serial_in_parallel_out_gather;
    logic clk = 0;
    logic reset_i = 1;
    logic valid_i = 0, yumi_i = 0;
    logic [31:0] data_i = '0;
    logic ready_and_o, valid_o;
    logic [127:0] data_o;
    logic v1 = 0, y1 = 0;
    logic [31:0] d1 = '0;
    logic r1_o, v1_o;
    logic [31:0] d1_o;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    bsg_serial_in_parallel_out_gather #(.width_p(32), .els_p(4)) dut (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .data_i(data_i),
        .ready_and_o(ready_and_o), .valid_o(valid_o), .data_o(data_o), .yumi_i(yumi_i));

    bsg_serial_in_parallel_out_gather #(.width_p(32), .els_p(1)) dut1 (
        .clk_i(clk), .reset_i(reset_i), .valid_i(v1), .data_i(d1),
        .ready_and_o(r1_o), .valid_o(v1_o), .data_o(d1_o), .yumi_i(y1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1;
        repeat (3) step();
        reset_i = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({valid_o, ready_and_o, data_o} !== {1'b0, 1'b1, 128'h0}) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d valid=%b ready=%b data=%h required valid=0 ready=1 data=0", i, valid_o, ready_and_o, data_o);
            end
            checks++;
            if ({v1_o, r1_o, d1_o} !== {1'b0, 1'b1, 32'h0}) begin
                failures++;
                $display("FAIL reset_idle_els1 cyc=%0d valid=%b ready=%b data=%h required 0/1/0", i, v1_o, r1_o, d1_o);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] w [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        for (int i = 0; i < 4; i++) begin
            valid_i = 1; data_i = w[i];
            checks++;
            if (ready_and_o !== 1'b1 || valid_o !== 1'b0) begin
                failures++;
                $display("FAIL basic_fill word=%0d ready=%b valid=%b required ready=1 valid=0", i, ready_and_o, valid_o);
            end
            step();
        end
        valid_i = 0;
        checks++;
        if ({valid_o, ready_and_o} !== 2'b10 || data_o !== 128'h44444444_33333333_22222222_11111111) begin
            failures++;
            $display("FAIL basic_beat valid=%b ready=%b data=%h required valid=1 ready=0 data=44444444333333332222222211111111", valid_o, ready_and_o, data_o);
        end
        yumi_i = 1;
        step();
        yumi_i = 0;
        checks++;
        if ({valid_o, ready_and_o} !== 2'b01) begin
            failures++;
            $display("FAIL basic_after_yumi valid=%b ready=%b required valid=0 ready=1", valid_o, ready_and_o);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] beat = {32'h104, 32'h103, 32'h102, 32'h101};
        for (int i = 0; i < 4; i++) begin
            valid_i = 1; data_i = 32'h101 + i;
            step();
        end
        data_i = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({valid_o, ready_and_o} !== 2'b10 || data_o !== beat) begin
                failures++;
                $display("FAIL backpressure_hold cyc=%0d valid=%b ready=%b data=%h required valid=1 ready=0 data=%h", i, valid_o, ready_and_o, data_o, beat);
            end
        end
        yumi_i = 1;
        step();
        yumi_i = 0;
        checks++;
        if ({valid_o, ready_and_o} !== 2'b01 || data_o !== beat) begin
            failures++;
            $display("FAIL backpressure_yumi valid=%b ready=%b data=%h required valid=0 ready=1 data=%h", valid_o, ready_and_o, data_o, beat);
        end
        step();
        valid_i = 0;
        checks++;
        if (data_o !== {32'h104, 32'h103, 32'h102, 32'hDEADBEEF} || valid_o !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_slot0 data=%h valid=%b required data=00000104000001030000010 2deadbeef valid=0", data_o, valid_o);
        end
        for (int i = 0; i < 3; i++) begin
            valid_i = 1; data_i = 32'h201 + i;
            step();
        end
        valid_i = 0;
        checks++;
        if (valid_o !== 1'b1 || data_o !== {32'h203, 32'h202, 32'h201, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL backpressure_beat2 valid=%b data=%h required valid=1 data=000002030000020200000201deadbeef", valid_o, data_o);
        end
        yumi_i = 1;
        step();
        yumi_i = 0;
    endtask

    task automatic test_streaming();
        int n = 1, beats = 0, cyc = 0, first = -1, last = -1;
        logic acc, yum;
        logic [127:0] expv;
        while (beats < 3 && cyc < 40) begin
            yumi_i  = valid_o;
            valid_i = n <= 12;
            data_i  = 32'(n);
            if (yumi_i) begin
                expv = {32'(4*beats+4), 32'(4*beats+3), 32'(4*beats+2), 32'(4*beats+1)};
                checks++;
                if (data_o !== expv) begin
                    failures++;
                    $display("FAIL stream_beat%0d data=%h required %h", beats, data_o, expv);
                end
            end
            acc = valid_i & ready_and_o;
            yum = yumi_i;
            step();
            cyc++;
            if (acc) begin n++; if (first < 0) first = cyc; end
            if (yum) begin beats++; last = cyc; end
        end
        valid_i = 0; yumi_i = 0;
        checks++;
        if (beats != 3 || last - first + 1 != 15) begin
            failures++;
            $display("FAIL stream_timing beats=%0d cycles=%0d required beats=3 cycles=15", beats, last - first + 1);
        end
    endtask

    task automatic test_reset_mid();
        valid_i = 1; data_i = 32'hA; step();
        data_i = 32'hB; step();
        valid_i = 0; reset_i = 1; step();
        reset_i = 0;
        checks++;
        if ({valid_o, ready_and_o} !== 2'b01 || data_o !== 128'h0) begin
            failures++;
            $display("FAIL reset_mid_clear valid=%b ready=%b data=%h required valid=0 ready=1 data=0", valid_o, ready_and_o, data_o);
        end
        for (int i = 1; i <= 4; i++) begin
            valid_i = 1; data_i = 32'(i); step();
        end
        valid_i = 0;
        checks++;
        if (valid_o !== 1'b1 || data_o !== {32'h4, 32'h3, 32'h2, 32'h1}) begin
            failures++;
            $display("FAIL reset_mid_beat valid=%b data=%h required valid=1 data=00000004000000030000000200000001", valid_o, data_o);
        end
        yumi_i = 1; step(); yumi_i = 0;
    endtask

    task automatic test_gapped();
        for (int i = 0; i < 4; i++) begin
            valid_i = 1; data_i = 32'hC0 + i; step();
            valid_i = 0; step();
            if (i == 2) begin
                checks++;
                if (valid_o !== 1'b0 || data_o[95:0] !== {32'hC2, 32'hC1, 32'hC0}) begin
                    failures++;
                    $display("FAIL gapped_partial valid=%b data=%h required valid=0 low slots c2/c1/c0", valid_o, data_o);
                end
            end
        end
        checks++;
        if (valid_o !== 1'b1 || data_o !== {32'hC3, 32'hC2, 32'hC1, 32'hC0}) begin
            failures++;
            $display("FAIL gapped_beat valid=%b data=%h required valid=1 data=000000c3000000c2000000c1000000c0", valid_o, data_o);
        end
        yumi_i = 1; step(); yumi_i = 0;
    endtask

    task automatic test_els1();
        v1 = 1; d1 = 32'h5; step();
        checks++;
        if ({v1_o, r1_o} !== 2'b10 || d1_o !== 32'h5) begin
            failures++;
            $display("FAIL els1_first valid=%b ready=%b data=%h required valid=1 ready=0 data=5", v1_o, r1_o, d1_o);
        end
        y1 = 1; d1 = 32'h6; step();
        y1 = 0;
        checks++;
        if ({v1_o, r1_o} !== 2'b01) begin
            failures++;
            $display("FAIL els1_bubble valid=%b ready=%b required valid=0 ready=1", v1_o, r1_o);
        end
        step();
        v1 = 0;
        checks++;
        if (v1_o !== 1'b1 || d1_o !== 32'h6) begin
            failures++;
            $display("FAIL els1_second valid=%b data=%h required valid=1 data=6", v1_o, d1_o);
        end
        y1 = 1; step(); y1 = 0;
        checks++;
        if (v1_o !== 1'b0) begin
            failures++;
            $display("FAIL els1_drain valid=%b required 0", v1_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_streaming();
        test_reset_mid();
        test_gapped();
        test_els1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bsg_serial_in_parallel_out_gather.md
Name: bsg_serial_in_parallel_out_gather

Overview:
- Deserializer: accepts a stream of width_p-bit words on a valid/ready_and handshake.
- Packs els_p consecutive words into one els_p*width_p-bit output beat.
- Presents the beat on a valid/yumi handshake.
- Receive-side counterpart to the team's narrow buffered datapaths. Sits between a narrow link or FIFO and a wide consumer.

Parameters:
- width_p, 32, bits per input word (>=1)
- els_p, 4, words gathered per output beat (>=1; els_p=1 degenerates to a one-entry registered buffer)

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- reset_i  input  1  synchronous active-high reset
- valid_i  input  1  input word valid
- data_i  input  width_p  input word
- ready_and_o  output  1  block can accept a word this cycle
- valid_o  output  1  full beat available
- data_o  output  els_p*width_p  gathered beat; word k at bits [k*width_p +: width_p]
- yumi_i  input  1  consumer takes the beat this cycle; legal only when valid_o=1

Behaviour:
- State:
  - count_r, $clog2(els_p+1) bits, range 0..els_p
  - els_p data registers of width_p bits
- Reset (reset_i=1 at clock edge):
  - count_r=0, all data registers=0
  - Outputs after reset: valid_o=0, ready_and_o=1, data_o=0
  - Reset takes priority over valid_i and yumi_i in the same cycle.
  - Reset mid-gather discards partial words; no partial beat is ever emitted.
- Derived outputs (registered state only, no combinational input-to-output path):
  - ready_and_o = (count_r != els_p)
  - valid_o = (count_r == els_p)
- Input handshake:
  - A transfer occurs when valid_i & ready_and_o.
  - On transfer: data register[count_r] <= data_i; count_r <= count_r+1.
  - valid_i while ready_and_o=0 is ignored. The data registers and count_r do not change, and the producer must hold.
- Output handshake:
  - When yumi_i=1 (with valid_o=1), count_r <= 0 next cycle.
  - Data registers are not cleared; stale contents remain but valid_o=0.
- Simultaneous yumi_i and valid_i:
  - Cannot transfer, since ready_and_o=0 whenever valid_o=1.
  - The first word of the next beat is accepted no earlier than the cycle after yumi_i.
- Throughput and latency:
  - Max throughput is els_p words per els_p+1 cycles.
  - valid_o rises the cycle after the els_p-th input transfer, i.e. one cycle of latency from the last word.
- data_o:
  - Stable from valid_o rise until yumi_i.
  - Word order: the first word accepted lands in the least-significant slot.
- Illegal condition: yumi_i=1 while valid_o=0.
  - Flagged by a simulation assertion (error message, not $finish).
  - Must not corrupt state: count_r stays unchanged, and any concurrent input transfer proceeds normally.
- Wrap-around: after yumi_i, the next beat restarts at slot 0. No count overflow is possible because count_r saturates at els_p through ready_and_o.
- els_p=1: a one-entry buffer with one bubble between beats.

Test Plan:
- Reset then idle: hold reset_i 3 cycles, release, no valid_i for 10 cycles -> valid_o=0, ready_and_o=1, data_o=0 throughout.
- Basic gather (width_p=32, els_p=4):
  - Stimulus: valid_i=1 back-to-back with 0x11111111, 0x22222222, 0x33333333, 0x44444444; yumi_i=1 on the first valid_o cycle.
  - Required: valid_o rises the cycle after the 4th word; data_o=0x44444444_33333333_22222222_11111111; ready_and_o=0 for exactly that one cycle.
- Backpressure:
  - Stimulus: fill 4 words, hold yumi_i=0 for 5 cycles while valid_i=1 with data_i=0xDEADBEEF.
  - Required: data_o unchanged, ready_and_o=0, 0xDEADBEEF not captured.
  - After yumi_i: 0xDEADBEEF is accepted as slot 0 on the next cycle.
- Streaming:
  - Stimulus: 12 words valid_i=1 continuously, values 1..12; consumer asserts yumi_i immediately on valid_o.
  - Required: 3 beats {4,3,2,1}, {8,7,6,5}, {12,11,10,9}; total 15 cycles from first accept to last yumi_i.
- Reset mid-operation:
  - Stimulus: accept 0xA, 0xB, then pulse reset_i one cycle; send 0x1, 0x2, 0x3, 0x4.
  - Required: beat = {4,3,2,1}; 0xA and 0xB never appear on data_o.
- Gapped input and els_p=1 build:
  - Stimulus: valid_i toggles 1/0 each cycle; separately, an els_p=1 instance with words 0x5, 0x6 back-to-back.
  - Required: gapped case gathers correctly in order; els_p=1 case gives valid_o every other cycle with data_o=0x5 then 0x6.
